// File: rtl/aes_ctr_feeder.sv
// Counter-mode feeder for the AES-256 core. It issues one counter block per
// cycle and tracks the core's fixed latency so downstream logic knows which OUT words are valid.
module aes_ctr_feeder #(
  parameter int CORE_LAT = 16,
  parameter int CTR_W    = 32,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [127:0]     iv_i,
  input  logic [255:0]     key_in_i,
  input  logic [CNT_W-1:0] nblk_i,
  input  logic             stall_i,
  output logic [127:0]     state_o,
  output logic [255:0]     key_o,
  output logic             state_vld_o,
  output logic             out_vld_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fsm_e;

  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fsm_e                fsm_q, fsm_d;
  logic [127:0]        ctr_q, ctr_d;
  logic [127:0]        blk_q, blk_d;
  logic [255:0]        key_q, key_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                svld_q, svld_d;
  logic [CORE_LAT-1:0] sr_q, sr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Each issued block's valid bit moves through this shift register, matching the core pipeline.
  if (CORE_LAT == 1) begin : g_sr_one
    assign sr_d = svld_q;
  end else begin : g_sr_many
    assign sr_d = {sr_q[CORE_LAT-2:0], svld_q};
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    fsm_d  = fsm_q;
    ctr_d  = ctr_q;
    blk_d  = blk_q;
    key_d  = key_q;
    rem_d  = rem_q;
    svld_d = 1'b0;
    done_d = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (load_i) begin
          ctr_d = iv_i;
          key_d = key_in_i;
          rem_d = nblk_i;
          fsm_d = (nblk_i != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (!stall_i && rem_q != '0) begin
          blk_d  = ctr_q;
          svld_d = 1'b1;
          // Only the low counter field increments; a wrap does not carry into the nonce.
          ctr_d[CTR_W-1:0] = ctr_q[CTR_W-1:0] + CTR_ONE;
          rem_d  = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) fsm_d = DRAIN;
        end
      end
      DRAIN: begin
        // The job finishes on the edge that clears the last in-flight valid bit.
        // DONE is then high in the cycle right after the final OUT_VLD.
        if (!svld_q && sr_d == '0) begin
          done_d = 1'b1;
          fsm_d  = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    busy_d = (fsm_d != IDLE) || done_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q  <= IDLE;
      ctr_q  <= '0;
      blk_q  <= '0;
      key_q  <= '0;
      rem_q  <= '0;
      svld_q <= 1'b0;
      sr_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      ctr_q  <= ctr_d;
      blk_q  <= blk_d;
      key_q  <= key_d;
      rem_q  <= rem_d;
      svld_q <= svld_d;
      sr_q   <= sr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign state_o     = blk_q;
  assign key_o       = key_q;
  assign state_vld_o = svld_q;
  assign out_vld_o   = sr_q[CORE_LAT-1];
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_aes_ctr_feeder.sv
// Self-checking bench for aes_ctr_feeder. It runs directed vector jobs, hand-written corner sequences,
// and random jobs, and checks them against a per-job timeline model.
module tb_aes_ctr_feeder;

  localparam int CORE_LAT = 16;
  localparam int CTR_W    = 32;
  localparam int CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [127:0]     iv = '0;
  logic [255:0]     key_in = '0;
  logic [CNT_W-1:0] nblk = '0;
  logic             stall = 1'b0;
  logic [127:0]     state;
  logic [255:0]     key;
  logic             state_vld, out_vld, busy, done;

  int tests = 0;
  int fails = 0;
  bit stall_pat [256];

  aes_ctr_feeder #(.CORE_LAT(CORE_LAT), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .iv_i(iv), .key_in_i(key_in),
    .nblk_i(nblk), .stall_i(stall), .state_o(state), .key_o(key),
    .state_vld_o(state_vld), .out_vld_o(out_vld), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The model works from the rules only. Edge k (counted after the LOAD edge) issues when the core is
  // not stalled and blocks remain. The i-th issue carries IV+i in the low field. OUT_VLD is the issue
  // timeline shifted by CORE_LAT. DONE comes one cycle after the last OUT_VLD, or at edge 1 for an
  // empty job.
  task automatic run_job(input logic [127:0] j_iv, input logic [255:0] j_key, input int n,
                         input bit key_chg, input bit extra_load,
                         output logic [31:0] last_low, output int done_at, output int out_cnt);
    int slot [512];
    int issued, last_issue, exp_done;
    logic [127:0] exp_state;
    for (int j = 0; j < 512; j++) slot[j] = -1;
    issued = 0;
    last_issue = 0;
    for (int j = 1; j < 256 && issued < n; j++) begin
      if (!stall_pat[j]) begin
        slot[j] = issued;
        issued++;
        last_issue = j;
      end
    end
    exp_done = (n == 0) ? 1 : last_issue + CORE_LAT + 1;

    @(negedge clk);
    load = 1'b1; iv = j_iv; key_in = j_key; nblk = n; stall = 1'b0;
    @(posedge clk);
    last_low = '0; done_at = -1; out_cnt = 0;
    for (int k = 1; k <= exp_done + 2; k++) begin
      @(negedge clk);
      load  = extra_load && (k == 3);
      if (load) begin
        iv = ~j_iv; key_in = ~j_key; nblk = 99;
      end
      if (key_chg && k == 1) key_in = j_key ^ {8{32'hdeadbeef}};
      stall = stall_pat[k];
      @(posedge clk);
      #1;
      check("state_vld", state_vld, slot[k] >= 0);
      if (slot[k] >= 0) begin
        exp_state = j_iv;
        exp_state[31:0] = j_iv[31:0] + 32'(slot[k]);
        check("state", state, exp_state);
      end
      check("out_vld", out_vld, (k > CORE_LAT) && (slot[k-CORE_LAT] >= 0));
      check("done", done, k == exp_done);
      check("busy", busy, k <= exp_done);
      check("key_hold", key, j_key);
      if (state_vld) last_low = state[31:0];
      if (out_vld) out_cnt++;
      if (done && done_at < 0) done_at = k;
    end
    @(negedge clk);
    load = 1'b0; stall = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [127:0] iv;
    int           nblk;
    logic [7:0]   stall_mask;
    logic [31:0]  exp_last_low;
    int           exp_done_at;
    int           exp_out_cnt;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [31:0]  last_low;
    int           done_at, out_cnt, bad;
    logic [127:0] r_iv;
    logic [255:0] r_key;

    vecs[0] = '{"basic", 128'h00112233_44556677_8899AABB_00000000, 4, 8'h00, 32'h00000003, 21, 4};
    vecs[1] = '{"wrap",  128'h00112233_44556677_8899AABB_FFFFFFFE, 3, 8'h00, 32'h00000000, 20, 3};
    vecs[2] = '{"stall", 128'hCAFEF00D_12345678_9ABCDEF0_00000000, 3, 8'h06, 32'h00000002, 22, 3};
    vecs[3] = '{"zero",  128'h11111111_22222222_33333333_44444444, 0, 8'h00, 32'h00000000, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, '0);
    check("rst_key", key, '0);
    check("rst_state_vld", state_vld, 1'b0);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < 256; j++) stall_pat[j] = (j >= 1 && j <= 8) ? vecs[v].stall_mask[j-1] : 1'b0;
      r_key = {8{$urandom()}};
      run_job(vecs[v].iv, r_key, vecs[v].nblk, 1'b0, 1'b0, last_low, done_at, out_cnt);
      check({vecs[v].name, "_last_low"}, last_low, vecs[v].exp_last_low);
      check({vecs[v].name, "_done_at"}, done_at, vecs[v].exp_done_at);
      check({vecs[v].name, "_out_cnt"}, out_cnt, vecs[v].exp_out_cnt);
    end

    // A LOAD raised mid-run is ignored; the job still issues 8 blocks and KEY stays the same.
    for (int j = 0; j < 256; j++) stall_pat[j] = 1'b0;
    run_job(128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_00000010, {8{32'h13579bdf}}, 8, 1'b0, 1'b1,
            last_low, done_at, out_cnt);
    check("ignored_load_out_cnt", out_cnt, 8);
    check("ignored_load_last_low", last_low, 32'h00000017);

    // KEY_IN is changed right after capture, and KEY must keep the value that was captured.
    run_job(128'h0, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2,
            1'b1, 1'b0, last_low, done_at, out_cnt);
    check("key_capture_done_at", done_at, 2 + CORE_LAT + 1);

    // Reset arrives after 5 of 10 blocks have issued, so none of them may ever show as valid.
    @(negedge clk);
    load = 1'b1; iv = 128'hFEEDFACE_0BADF00D_DEADBEEF_00000000; key_in = {8{32'h0c0ffee0}}; nblk = 10;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      load = 1'b0;
      @(posedge clk);
    end
    #1;
    check("mid_state_vld_before_rst", state_vld, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_state", state, '0);
    check("midrst_key", key, '0);
    check("midrst_state_vld", state_vld, 1'b0);
    check("midrst_out_vld", out_vld, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 2 * CORE_LAT; k++) begin
      @(posedge clk);
      #1;
      if (out_vld || done || state_vld || busy) bad++;
    end
    check("post_rst_quiet", bad, 0);
    run_job(128'h1, {8{32'h01234567}}, 2, 1'b0, 1'b0, last_low, done_at, out_cnt);
    check("post_rst_job_out_cnt", out_cnt, 2);

    // Random jobs mix in counter values near the wrap point and random stalls.
    for (int t = 0; t < 8; t++) begin
      r_iv  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (t[0]) r_iv[31:0] = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
      r_key = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
      for (int j = 0; j < 256; j++) stall_pat[j] = ($urandom_range(0, 3) == 0);
      run_job(r_iv, r_key, $urandom_range(0, 12), t[1], t[2], last_low, done_at, out_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end

endmodule

// File: doc/aes_ctr_feeder.md
Name: aes_ctr_feeder

Overview:
Upstream counter-mode stage for the AES-256 pipeline. It captures a key, an initial counter block and a block count. It then streams one counter block per cycle into the core's STATE/KEY inputs, with a stall control for bubbles. A valid bit is shifted alongside the core's fixed latency so downstream logic knows which core OUT words are real keystream. A completion pulse follows once the last block has drained.

Parameters:
CORE_LAT, 16, cycles from this block's STATE/KEY outputs to a valid core OUT (core plus wrapper register stages); must be >=1
CTR_W, 32, width of the incrementing low field of the counter block; upper 128-CTR_W bits are fixed nonce
CNT_W, 32, width of the block-count field

Ports:
CLK  in  1  single clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
LOAD  in  1  start request, sampled only in IDLE
IV  in  128  initial counter block
KEY_IN  in  256  AES-256 key
NBLK  in  CNT_W  number of blocks to issue
STALL  in  1  when high in RUN, no block issued this cycle
STATE  out  128  counter block to core (registered)
KEY  out  256  key to core (registered, constant during a job)
STATE_VLD  out  1  STATE holds a newly issued block this cycle
OUT_VLD  out  1  core OUT is valid keystream this cycle
BUSY  out  1  high in RUN or DRAIN
DONE  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (sync, any state, including mid-job): FSM to IDLE; STATE=0, KEY=0, STATE_VLD=0, OUT_VLD=0, BUSY=0, DONE=0; internal counter, remaining count and the valid shift register all cleared. Core outputs from blocks in flight are never flagged valid.
- FSM states are IDLE, RUN and DRAIN.
- IDLE: on an edge with LOAD=1:
  - ctr<=IV, KEY<=KEY_IN, rem<=NBLK.
  - If NBLK!=0, go to RUN; else go to DRAIN, which yields DONE per the DRAIN rule with no issue.
- LOAD in RUN or DRAIN is ignored. No queuing.
- RUN: each edge with STALL=0 and rem!=0:
  - STATE<=ctr, STATE_VLD<=1.
  - ctr[CTR_W-1:0]<=ctr[CTR_W-1:0]+1 modulo 2^CTR_W; the upper bits never change (wrap 0xFFFFFFFF->0x00000000 with no carry).
  - rem<=rem-1.
  - If rem==1, go to DRAIN.
- RUN with STALL=1: STATE_VLD<=0. STATE, ctr and rem hold.
- Latency: LOAD sampled at edge e. The first block is issued at edge e+1, so STATE_VLD is high in the cycle after e+1. With STALL low, blocks are issued back-to-back, one per cycle.
- STATE_VLD is 0 on every edge that does not issue. STATE holds its last value.
- OUT_VLD equals STATE_VLD delayed by exactly CORE_LAT cycles, via a CORE_LAT-deep shift register cleared by reset.
- DRAIN: on the first edge where STATE_VLD=0 and the shift register is all zero, DONE<=1 and go to IDLE. DONE falls on the next edge. DONE is therefore high in the cycle after the last OUT_VLD cycle.
- BUSY is registered and equals (state!=IDLE). It is high from the cycle after the LOAD edge through the DONE cycle inclusive.
- KEY holds constant from LOAD capture until the next accepted LOAD.

Test Plan:
- Basic job: RST, then LOAD with IV=0x00112233_44556677_8899AABB_00000000, NBLK=4, STALL=0 -> STATE_VLD high for 4 consecutive cycles starting at LOAD edge+1. Low words are 0,1,2,3 with the upper 96 bits unchanged. OUT_VLD replicates this pattern exactly CORE_LAT cycles later. DONE pulses once, 1 cycle after the last OUT_VLD.
- Wrap: IV low word 0xFFFFFFFE, NBLK=3 -> low words 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; upper 96 bits identical on all three.
- Stall: NBLK=3, STALL high for 2 cycles after the first issue -> issued low words 0,1,2 with a 2-cycle STATE_VLD gap. OUT_VLD shows the same gap; exactly 3 OUT_VLD cycles in total.
- Zero/ignored load: LOAD with NBLK=0 -> no STATE_VLD or OUT_VLD; DONE pulses a few cycles later. A second LOAD asserted mid-RUN (NBLK=8 job) -> ignored; still exactly 8 blocks issued and KEY unchanged.
- Reset mid-job: NBLK=10, assert RST after 5 issues while OUT_VLD is still low -> next cycle all outputs 0. OUT_VLD stays 0 for the following 2*CORE_LAT cycles. No DONE. A new LOAD then runs normally.
- Key capture: KEY_IN=0x000102...1F changed one cycle after LOAD -> KEY holds the captured value for the whole job.
